// File: rtl/cpu_ctrl_pkg.sv
// Encodings shared between the control FSM and the datapath register bank.
package cpu_ctrl_pkg;

  // B-bus source selects
  localparam logic [2:0] BSRC_DRAM = 3'd0;
  localparam logic [2:0] BSRC_PC   = 3'd1;
  localparam logic [2:0] BSRC_R1   = 3'd2;
  localparam logic [2:0] BSRC_R2   = 3'd3;
  localparam logic [2:0] BSRC_R3   = 3'd4;
  localparam logic [2:0] BSRC_R    = 3'd5;
  localparam logic [2:0] BSRC_AC   = 3'd6;
  localparam logic [2:0] BSRC_IRAM = 3'd7;

  // ALU operations
  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_PASSB  = 3'd2;
  localparam logic [2:0] ALU_ZERO   = 3'd3;
  localparam logic [2:0] ALU_DEC    = 3'd4;
  localparam logic [2:0] ALU_SHL8   = 3'd5;
  localparam logic [2:0] ALU_SHR1   = 3'd6;
  localparam logic [2:0] ALU_PASSAC = 3'd7;

  // Write-enable bit positions within cflag
  localparam int unsigned CF_AR = 7;
  localparam int unsigned CF_PC = 6;
  localparam int unsigned CF_R1 = 5;
  localparam int unsigned CF_R2 = 4;
  localparam int unsigned CF_R3 = 3;
  localparam int unsigned CF_R  = 2;
  localparam int unsigned CF_AC = 1;
  localparam int unsigned CF_M  = 0;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: a is the accumulator, b is the B bus. Results wrap modulo 2^DATA_W.
module datapath_alu
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  localparam logic [DATA_W-1:0] One = DATA_W'(1);

  // Operation decode
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_PASSB:  y = b;
      ALU_ZERO:   y = '0;
      ALU_DEC:    y = a - One;
      ALU_SHL8:   y = a << 8;
      ALU_SHR1:   y = a >> 1;
      ALU_PASSAC: y = a;
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/datapath_regbank.sv
// Processor datapath: register bank, B-bus mux, ALU, instruction register and retired-fetch counter.
module datapath_regbank
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pcinc,
  input  logic              r1inc,
  input  logic              r2inc,
  input  logic              r3inc,
  input  logic              acinc,
  input  logic              fetch,
  input  logic              finish,
  input  logic [2:0]        alu,
  input  logic [2:0]        bflag,
  input  logic [7:0]        cflag,
  input  logic [7:0]        iram_rdata,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic              dram_we,
  output logic [7:0]        ir,
  output logic              z,
  output logic [DATA_W-1:0] ac_q,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam logic [DATA_W-1:0] One    = DATA_W'(1);
  localparam logic [CNT_W-1:0]  CntOne = CNT_W'(1);

  logic [DATA_W-1:0] ar_q, pc_q, r1_q, r2_q, r3_q, r_q;
  logic [DATA_W-1:0] ar_d, pc_d, r1_d, r2_d, r3_d, r_d, ac_d;
  logic [7:0]        ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] bbus;
  logic [DATA_W-1:0] alu_y;

  // B-bus source mux
  always_comb begin
    bbus = '0;
    case (bflag)
      BSRC_DRAM: bbus = dram_rdata;
      BSRC_PC:   bbus = pc_q;
      BSRC_R1:   bbus = r1_q;
      BSRC_R2:   bbus = r2_q;
      BSRC_R3:   bbus = r3_q;
      BSRC_R:    bbus = r_q;
      BSRC_AC:   bbus = ac_q;
      BSRC_IRAM: bbus = {{(DATA_W-8){1'b0}}, iram_rdata};
      default:   bbus = '0;
    endcase
  end

  datapath_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op (alu),
    .a  (ac_q),
    .b  (bbus),
    .y  (alu_y)
  );

  // Next-state: a cflag write takes precedence over an increment of the same register
  always_comb begin
    ar_d  = ar_q;
    pc_d  = pc_q;
    r1_d  = r1_q;
    r2_d  = r2_q;
    r3_d  = r3_q;
    r_d   = r_q;
    ac_d  = ac_q;
    ir_d  = ir_q;
    cnt_d = cnt_q;

    if (cflag[CF_AR]) ar_d = bbus;

    if (cflag[CF_PC])  pc_d = bbus;
    else if (pcinc)    pc_d = pc_q + One;

    if (cflag[CF_R1])  r1_d = bbus;
    else if (r1inc)    r1_d = r1_q + One;

    if (cflag[CF_R2])  r2_d = bbus;
    else if (r2inc)    r2_d = r2_q + One;

    if (cflag[CF_R3])  r3_d = bbus;
    else if (r3inc)    r3_d = r3_q + One;

    if (cflag[CF_R]) r_d = bbus;

    if (cflag[CF_AC])  ac_d = alu_y;
    else if (acinc)    ac_d = ac_q + One;

    if (fetch) ir_d = bbus[7:0];

    // Counter sticks at all-ones rather than wrapping
    if (fetch && !finish && (cnt_q != '1)) cnt_d = cnt_q + CntOne;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar_q  <= '0;
      pc_q  <= '0;
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      r_q   <= '0;
      ac_q  <= '0;
      ir_q  <= 8'h00;
      cnt_q <= '0;
    end else begin
      ar_q  <= ar_d;
      pc_q  <= pc_d;
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      r3_q  <= r3_d;
      r_q   <= r_d;
      ac_q  <= ac_d;
      ir_q  <= ir_d;
      cnt_q <= cnt_d;
    end
  end

  // Memory-side outputs; DRAM address is the pre-edge AR, so a same-cycle AR write is not seen
  always_comb begin
    iram_addr  = pc_q[ADDR_W-1:0];
    dram_addr  = ar_q[ADDR_W-1:0];
    dram_wdata = bbus;
    dram_we    = cflag[CF_M];
    ir         = ir_q;
    z          = (ac_q == '0);
    instr_cnt  = cnt_q;
  end

endmodule
